// File: rtl/m_deser_pkg.sv
// Shared types and constants for the m_deser serial receive stage.
// Optional even-parity support is selected with M_DESER_PARITY_EN.
package m_deser_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DATA = 3'd1,
    S_PAR  = 3'd2,
    S_STOP = 3'd3,
    S_WAIT = 3'd4
  } state_e;

endpackage

// File: rtl/m_bitcnt.sv
// Data-bit counter for m_deser: clear, enable, saturates at WIDTH,
// terminal count flags the last data bit (WIDTH-1).
module m_bitcnt
  import m_deser_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic w_clk,
  input  logic w_rst_n,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CW'(WIDTH))) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc_c = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/m_deser.sv
// Serial-to-parallel receiver: start=1, WIDTH data bits LSB first, stop=0.
// Define M_DESER_PARITY_EN to insert an even-parity bit before the stop bit.
module m_deser
  import m_deser_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             w_clk,
  input  logic             w_rst_n,
  input  logic             w_in,
  output logic [WIDTH-1:0] w_data,
  output logic             w_valid,
  output logic             w_err,
  output logic             w_busy
);

  state_e           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [WIDTH-1:0] data_nx;
  logic             valid_nx, err_nx;
  logic             cnt_clr, cnt_en, cnt_tc_c;
  logic             par_fail;
`ifdef M_DESER_PARITY_EN
  logic             par_err, par_err_nx;
`endif

  m_bitcnt #(.WIDTH(WIDTH)) u_bitcnt (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .tc_c    (cnt_tc_c)
  );

  // State, shift register and registered outputs
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state   <= S_IDLE;
      shreg   <= '0;
      w_data  <= '0;
      w_valid <= 1'b0;
      w_err   <= 1'b0;
      w_busy  <= 1'b0;
`ifdef M_DESER_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      w_data  <= data_nx;
      w_valid <= valid_nx;
      w_err   <= err_nx;
      w_busy  <= (state_nx != S_IDLE);
`ifdef M_DESER_PARITY_EN
      par_err <= par_err_nx;
`endif
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    data_nx  = w_data;
    valid_nx = 1'b0;
    err_nx   = 1'b0;
    cnt_clr  = 1'b1;
    cnt_en   = 1'b0;
    par_fail = 1'b0;
`ifdef M_DESER_PARITY_EN
    par_err_nx = par_err;
    par_fail   = par_err;
`endif
    case (state)
      S_IDLE: begin
        if (w_in == START_BIT) state_nx = S_DATA;
      end
      S_DATA: begin
        cnt_clr  = 1'b0;
        cnt_en   = 1'b1;
        // LSB arrives first, so after WIDTH shifts it sits at bit 0
        shreg_nx = {w_in, shreg[WIDTH-1:1]};
        if (cnt_tc_c) begin
`ifdef M_DESER_PARITY_EN
          state_nx = S_PAR;
`else
          state_nx = S_STOP;
`endif
        end
      end
`ifdef M_DESER_PARITY_EN
      S_PAR: begin
        par_err_nx = ^{shreg, w_in};
        state_nx   = S_STOP;
      end
`endif
      S_STOP: begin
        if ((w_in == STOP_BIT) && !par_fail) begin
          data_nx  = shreg;
          valid_nx = 1'b1;
          state_nx = S_IDLE;
        end else begin
          err_nx   = 1'b1;
          state_nx = (w_in == STOP_BIT) ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_in == STOP_BIT) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_m_deser.sv
// Self-checking bench for m_deser: frames are scheduled as a bit timeline with
// per-bit expected outputs derived from the frame layout; honours M_DESER_PARITY_EN.
module tb_m_deser;

  localparam int unsigned W = 8;

  logic         w_clk;
  logic         w_rst_n;
  logic         w_in;
  logic [W-1:0] w_data;
  logic         w_valid;
  logic         w_err;
  logic         w_busy;

  int n_vec  = 0;
  int n_miss = 0;

  logic [W-1:0] model_data;

  bit           bits_q[$];
  bit           busy_q[$];
  bit           valid_q[$];
  bit           err_q[$];
  logic [W-1:0] vdata_q[$];

  m_deser #(.WIDTH(W)) dut (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .w_in    (w_in),
    .w_data  (w_data),
    .w_valid (w_valid),
    .w_err   (w_err),
    .w_busy  (w_busy)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit b, input bit busy, input bit v, input bit e, input logic [W-1:0] d);
    bits_q.push_back(b);
    busy_q.push_back(busy);
    valid_q.push_back(v);
    err_q.push_back(e);
    vdata_q.push_back(d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // One frame; outputs after the stop-bit edge depend on stop and parity
  task automatic frame(input logic [W-1:0] d, input bit stop, input bit par_flip);
    bit good;
    good = (stop == 1'b0) && (par_flip == 1'b0);
    push(1'b1, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < int'(W); i++) push(d[i], 1'b1, 1'b0, 1'b0, '0);
`ifdef M_DESER_PARITY_EN
    push((^d) ^ par_flip, 1'b1, 1'b0, 1'b0, '0);
`endif
    push(stop, stop, good, !good, d);
  endtask

  // Line stuck high after a bad stop bit, then released
  task automatic hold_high(input int n);
    for (int i = 0; i < n; i++) push(1'b1, 1'b1, 1'b0, 1'b0, '0);
    push(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic play();
    for (int i = 0; i < bits_q.size(); i++) begin
      w_in = bits_q[i];
      @(posedge w_clk);
      #1;
      if (valid_q[i]) model_data = vdata_q[i];
      chk("valid", W'(w_valid), W'(valid_q[i]));
      chk("err",   W'(w_err),   W'(err_q[i]));
      chk("busy",  W'(w_busy),  W'(busy_q[i]));
      chk("data",  w_data,      model_data);
    end
    bits_q.delete();
    busy_q.delete();
    valid_q.delete();
    err_q.delete();
    vdata_q.delete();
  endtask

  initial begin
    bit par_flip;
    w_in       = 1'b0;
    w_rst_n    = 1'b0;
    model_data = '0;
    #12;
    chk("rst_data",  w_data,         '0);
    chk("rst_valid", W'(w_valid),    '0);
    chk("rst_err",   W'(w_err),      '0);
    chk("rst_busy",  W'(w_busy),     '0);
    w_rst_n = 1'b1;
    @(posedge w_clk);
    #1;

    // Single good frame, then zero-gap pair
    idle(2);
    frame(8'hA5, 1'b0, 1'b0);
    idle(3);
    frame(8'h3C, 1'b0, 1'b0);
    frame(8'hC3, 1'b0, 1'b0);
    idle(2);
    // Bad stop, line stuck high
    frame(8'h5A, 1'b1, 1'b0);
    hold_high(5);
    idle(2);
    play();

    // Asynchronous reset after the 4th data bit of 0xFF
    w_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge w_clk);
      #1;
    end
    chk("pre_rst_busy", W'(w_busy), W'(1'b1));
    #2;
    w_rst_n = 1'b0;
    #1;
    model_data = '0;
    chk("arst_data",  w_data,      '0);
    chk("arst_valid", W'(w_valid), '0);
    chk("arst_err",   W'(w_err),   '0);
    chk("arst_busy",  W'(w_busy),  '0);
    w_in = 1'b0;
    @(posedge w_clk);
    #2;
    w_rst_n = 1'b1;
    idle(3);
    frame(8'h01, 1'b0, 1'b0);
    idle(50);
    play();

`ifdef M_DESER_PARITY_EN
    frame(8'h07, 1'b0, 1'b0);
    idle(1);
    frame(8'h07, 1'b0, 1'b1);
    idle(2);
    play();
`endif

    // Randomized frames, gaps and line faults
    for (int f = 0; f < 40; f++) begin
      bit bad_stop;
      idle(int'($urandom_range(0, 3)));
      bad_stop = ($urandom_range(0, 7) == 0);
      par_flip = 1'b0;
`ifdef M_DESER_PARITY_EN
      par_flip = ($urandom_range(0, 5) == 0);
`endif
      frame(W'($urandom), bad_stop, par_flip);
      if (bad_stop) hold_high(int'($urandom_range(0, 4)));
    end
    idle(3);
    play();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
